cfg_chain_loader: RTL and testbench

//  Transmit end of the logic-cell configuration shift chain. Accepts config bytes over a

---
 rtl/cfg_chain_pkg.sv | 8 +
 rtl/cfg_crc8.sv | 21 ++
 rtl/cfg_chain_loader.sv | 131 +++++++++++++
 tb/tb_cfg_chain_loader.sv | 284 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cfg_chain_pkg.sv
// rtl/cfg_chain_pkg.sv - shared state encoding and CRC polynomial for the config chain loader
package cfg_chain_pkg;

    typedef enum logic [1:0] {IDLE, WAIT_BYTE, SHIFT, DONE} cfg_state_t;

    localparam logic [7:0] CRC8_POLY = 8'h07;

endpackage

// File: rtl/cfg_crc8.sv
// rtl/cfg_crc8.sv - bitwise MSB-fed CRC-8 accumulator, init 0x00, cleared by reset or clr
module cfg_crc8
    import cfg_chain_pkg::*;
(
    input  logic       clock,
    input  logic       reset,
    input  logic       clr,
    input  logic       en,
    input  logic       bit_in,
    output logic [7:0] crc
);

    always_ff @(posedge clock) begin
        if (reset || clr) begin
            crc <= 8'h00;
        end else if (en) begin
            crc <= {crc[6:0], 1'b0} ^ ((crc[7] ^ bit_in) ? CRC8_POLY : 8'h00);
        end
    end

endmodule

// File: rtl/cfg_chain_loader.sv
// rtl/cfg_chain_loader.sv - byte stream to config shift chain serialiser; CFG_CRC_EN adds tx/rx CRC-8
module cfg_chain_loader
    import cfg_chain_pkg::*;
#(
    parameter int CHAIN_LEN = 64,
    parameter int BYTE_W    = 8
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              start,
    input  logic              abort,
    input  logic [BYTE_W-1:0] data_in,
    input  logic              data_valid,
    output logic              data_ready,
    output logic              cfg_shift,
    output logic              cfg_en,
    input  logic              chain_tail,
    output logic              busy,
    output logic              done,
    output logic [7:0]        crc_tx,
    output logic [7:0]        crc_rx
);

    localparam int CNT_W = $clog2(CHAIN_LEN + 1);
    localparam int IDX_W = (BYTE_W > 1) ? $clog2(BYTE_W) : 1;
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(CHAIN_LEN - 1);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(BYTE_W - 1);

    cfg_state_t        state;
    logic [BYTE_W-1:0] sreg;
    logic [CNT_W-1:0]  bit_cnt;
    logic [IDX_W-1:0]  bit_idx;
    logic              last_chain_bit;
    logic              last_byte_bit;
    logic              accept;

    assign last_chain_bit = (bit_cnt == LAST_BIT);
    assign last_byte_bit  = (bit_idx == LAST_IDX);

    // Next byte may be taken during the final bit of the current one, but never once the chain is full.
    assign data_ready = !abort && ((state == WAIT_BYTE) ||
                                   ((state == SHIFT) && last_byte_bit && !last_chain_bit));
    assign accept     = data_valid && data_ready;

    assign cfg_en    = (state == SHIFT);
    assign cfg_shift = cfg_en & sreg[0];
    assign busy      = (state != IDLE);
    assign done      = (state == DONE);

    always_ff @(posedge clock) begin
        if (reset) begin
            state   <= IDLE;
            sreg    <= '0;
            bit_cnt <= '0;
            bit_idx <= '0;
        end else if (abort) begin
            state <= IDLE;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        state   <= WAIT_BYTE;
                        bit_cnt <= '0;
                        bit_idx <= '0;
                    end
                end
                WAIT_BYTE: begin
                    if (accept) begin
                        sreg    <= data_in;
                        bit_idx <= '0;
                        state   <= SHIFT;
                    end
                end
                SHIFT: begin
                    bit_cnt <= bit_cnt + 1'b1;
                    if (last_chain_bit) begin
                        state <= DONE;
                    end else if (last_byte_bit) begin
                        // Chain holds (cfg_en low) while waiting for a late byte.
                        if (accept) begin
                            sreg    <= data_in;
                            bit_idx <= '0;
                        end else begin
                            state <= WAIT_BYTE;
                        end
                    end else begin
                        sreg    <= sreg >> 1;
                        bit_idx <= bit_idx + 1'b1;
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

`ifdef CFG_CRC_EN
    logic crc_clr;

    assign crc_clr = (state == IDLE) && start && !abort;

    cfg_crc8 u_crc_tx (
        .clock  (clock),
        .reset  (reset),
        .clr    (crc_clr),
        .en     (cfg_en),
        .bit_in (cfg_shift),
        .crc    (crc_tx)
    );

    cfg_crc8 u_crc_rx (
        .clock  (clock),
        .reset  (reset),
        .clr    (crc_clr),
        .en     (cfg_en),
        .bit_in (chain_tail),
        .crc    (crc_rx)
    );
`else
    logic unused_tail;

    assign unused_tail = chain_tail;
    assign crc_tx      = 8'h00;
    assign crc_rx      = 8'h00;
`endif

endmodule

// File: tb/tb_cfg_chain_loader.sv
// tb/tb_cfg_chain_loader.sv - self-checking bench for cfg_chain_loader (CHAIN_LEN 12 and 16)
module tb_cfg_chain_loader;

    localparam int LEN = 12;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       start = 1'b0;
    logic       abort = 1'b0;
    logic [7:0] data_in = 8'h00;
    logic       data_valid = 1'b0;
    logic       data_ready, cfg_shift, cfg_en, chain_tail, busy, done;
    logic [7:0] crc_tx, crc_rx;

    logic       start16 = 1'b0;
    logic [7:0] data16 = 8'h00;
    logic       valid16 = 1'b0;
    logic       ready16, shift16, en16, busy16, done16;
    logic [7:0] crc_tx16, crc_rx16;

    logic [LEN-1:0] tb_chain = '0;

    always #5 clock = ~clock;

    cfg_chain_loader #(.CHAIN_LEN(LEN), .BYTE_W(8)) u_dut (
        .clock(clock), .reset(reset), .start(start), .abort(abort),
        .data_in(data_in), .data_valid(data_valid), .data_ready(data_ready),
        .cfg_shift(cfg_shift), .cfg_en(cfg_en), .chain_tail(chain_tail),
        .busy(busy), .done(done), .crc_tx(crc_tx), .crc_rx(crc_rx)
    );

    cfg_chain_loader #(.CHAIN_LEN(16), .BYTE_W(8)) u_dut16 (
        .clock(clock), .reset(reset), .start(start16), .abort(1'b0),
        .data_in(data16), .data_valid(valid16), .data_ready(ready16),
        .cfg_shift(shift16), .cfg_en(en16), .chain_tail(1'b0),
        .busy(busy16), .done(done16), .crc_tx(crc_tx16), .crc_rx(crc_rx16)
    );

    // Loopback chain of LEN cells: tail presents the oldest bit while the chain shifts.
    always @(posedge clock) if (cfg_en) tb_chain <= {tb_chain[LEN-2:0], cfg_shift};
    assign chain_tail = tb_chain[LEN-1];

    typedef struct {
        logic [7:0]     b0;
        logic [7:0]     b1;
        int             g0;
        int             g1;
        bit             poke;
        logic [LEN-1:0] seq;
        int             bub;
    } vec_t;

    vec_t tbl[4];
    int   vectors = 0;
    int   miscompares = 0;

    logic [15:0] obs_bits;
    int          obs_n, bubbles, done_n, done_after, ready7, ready_last, leak;
    logic        prev_en;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic mon_clear();
        obs_bits = '0; obs_n = 0; bubbles = 0; done_n = 0;
        done_after = 0; ready7 = 0; ready_last = 0; leak = 0; prev_en = 1'b0;
    endtask

    // Samples the loader at the falling edge, then advances to just after the next rising edge.
    task automatic tick();
        @(negedge clock);
        if (cfg_en) begin
            if (obs_n == 7 && data_ready) ready7++;
            if (obs_n == LEN - 1 && data_ready) ready_last++;
            if (obs_n < 16) obs_bits[obs_n] = cfg_shift;
            obs_n++;
        end else begin
            if (cfg_shift) leak++;
            if (busy && !done && obs_n > 0 && obs_n < LEN) bubbles++;
        end
        if (done) begin
            done_n++;
            if (prev_en) done_after++;
            if (data_ready) ready_last++;
        end
        prev_en = cfg_en;
        @(posedge clock);
        #2;
    endtask

    task automatic offer(input logic [7:0] b, input string tag);
        int n = 0;
        data_valid = 1'b1;
        data_in    = b;
        while (!data_ready && n < 60) begin
            tick();
            n++;
        end
        chk({tag, ".accept_in_time"}, 32'(n < 60), 32'd1);
        tick();
        data_valid = 1'b0;
        data_in    = 8'($urandom);
    endtask

    task automatic run_load(input vec_t v, input string tag);
        int n = 0;
        mon_clear();
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (v.g0) tick();
        offer(v.b0, tag);
        for (int i = 0; i < v.g1; i++) begin
            start = v.poke && (i == 0);
            tick();
        end
        start = 1'b0;
        offer(v.b1, tag);
        while (done_n == 0 && n < 40) begin
            tick();
            n++;
        end
        tick();
        tick();
        chk({tag, ".seq"}, 32'(obs_bits[LEN-1:0]), 32'(v.seq));
        chk({tag, ".en_cycles"}, 32'(obs_n), 32'(LEN));
        chk({tag, ".bubbles"}, 32'(bubbles), 32'(v.bub));
        chk({tag, ".done_pulses"}, 32'(done_n), 32'd1);
        chk({tag, ".done_after_last_bit"}, 32'(done_after), 32'd1);
        chk({tag, ".ready_bit7"}, 32'(ready7), 32'd1);
        chk({tag, ".ready_after_final"}, 32'(ready_last), 32'd0);
        chk({tag, ".shift_leak"}, 32'(leak), 32'd0);
        chk({tag, ".idle_after"}, 32'(busy), 32'd0);
    endtask

    function automatic logic [7:0] crc_ref(input logic [LEN-1:0] bits);
        logic [7:0] c = 8'h00;
        for (int i = 0; i < LEN; i++) begin
            logic fb = c[7] ^ bits[i];
            c = {c[6:0], 1'b0};
            if (fb) c = c ^ 8'h07;
        end
        return c;
    endfunction

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t        v;
        logic [7:0]  c1;
        logic [15:0] seq16, rdy16;
        int          k, acc, seen;

        mon_clear();
        repeat (3) tick();
        chk("reset.outputs", 32'({cfg_en, cfg_shift, data_ready, busy, done}), 32'd0);
        reset = 1'b0;
        tick();

        tbl[0] = '{8'hA5, 8'h03, 0, 0,  1'b0, 12'h3A5, 0};
        tbl[1] = '{8'hA5, 8'h03, 2, 10, 1'b0, 12'h3A5, 3};
        tbl[2] = '{8'h5A, 8'hFC, 1, 4,  1'b1, 12'hC5A, 0};
        tbl[3] = '{8'h00, 8'hFF, 0, 8,  1'b0, 12'hF00, 1};
        for (int i = 0; i < 4; i++) run_load(tbl[i], $sformatf("tbl%0d", i));

        for (int i = 0; i < 6; i++) begin
            v.b0   = 8'($urandom);
            v.b1   = 8'($urandom);
            v.g0   = $urandom_range(0, 3);
            v.g1   = $urandom_range(0, 12);
            v.poke = 1'b0;
            v.seq  = {v.b1[3:0], v.b0};
            v.bub  = (v.g1 > 7) ? v.g1 - 7 : 0;
            run_load(v, $sformatf("rnd%0d", i));
        end

        // Abort after five shifted bits.
        mon_clear();
        start = 1'b1;
        tick();
        start = 1'b0;
        offer(8'hA5, "abort");
        repeat (4) tick();
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("abort.en_low", 32'(cfg_en), 32'd0);
        chk("abort.idle", 32'(busy), 32'd0);
        repeat (3) tick();
        chk("abort.bits_shifted", 32'(obs_n), 32'd5);
        chk("abort.no_done", 32'(done_n), 32'd0);

        // Abort in WAIT_BYTE blocks the offered byte.
        start = 1'b1;
        tick();
        start = 1'b0;
        data_valid = 1'b1;
        abort = 1'b1;
        #1;
        chk("abort_wait.ready_low", 32'(data_ready), 32'd0);
        tick();
        abort = 1'b0;
        data_valid = 1'b0;
        chk("abort_wait.idle", 32'(busy), 32'd0);
        run_load(tbl[0], "after_abort");

        start = 1'b1;
        abort = 1'b1;
        tick();
        start = 1'b0;
        abort = 1'b0;
        chk("start_abort_idle.busy", 32'(busy), 32'd0);

        // Reset mid-shift.
        start = 1'b1;
        tick();
        start = 1'b0;
        offer(8'hFF, "reset_mid");
        repeat (3) tick();
        chk("reset_mid.in_shift", 32'(cfg_en), 32'd1);
        reset = 1'b1;
        tick();
        chk("reset_mid.outputs", 32'({cfg_en, cfg_shift, data_ready, busy, done}), 32'd0);
        chk("reset_mid.crc", 32'({crc_tx, crc_rx}), 32'd0);
        reset = 1'b0;
        tick();

        // CHAIN_LEN=16: 0xFF then 0x00, a third byte stays offered and must never be taken.
        start16 = 1'b1;
        tick();
        start16 = 1'b0;
        valid16 = 1'b1;
        data16  = 8'hFF;
        seq16 = '0; rdy16 = '0; k = 0; acc = 0; seen = 0;
        for (int c = 0; c < 60 && seen == 0; c++) begin
            if (en16) begin
                if (k < 16) begin
                    rdy16[k] = ready16;
                    seq16[k] = shift16;
                end
                k++;
            end
            if (done16) seen = 1;
            if (valid16 && ready16) acc++;
            tick();
            data16 = (acc == 0) ? 8'hFF : (acc == 1) ? 8'h00 : 8'hAA;
        end
        valid16 = 1'b0;
        chk("len16.seq", 32'(seq16), 32'h00FF);
        chk("len16.en_cycles", 32'(k), 32'd16);
        chk("len16.ready_mask", 32'(rdy16), 32'h0080);
        chk("len16.bytes_taken", 32'(acc), 32'd2);
        chk("len16.done_seen", 32'(seen), 32'd1);
        tick();
        chk("len16.idle", 32'(busy16), 32'd0);

        // Reload through the looped-back chain.
        run_load(tbl[0], "crc_load1");
        c1 = crc_tx;
        run_load(tbl[0], "crc_load2");
`ifdef CFG_CRC_EN
        chk("crc.tx_value", 32'(c1), 32'(crc_ref(12'h3A5)));
        chk("crc.tx_repeat", 32'(crc_tx), 32'(c1));
        chk("crc.rx_matches_prev_tx", 32'(crc_rx), 32'(c1));
`else
        chk("crc.tx_tied", 32'(crc_tx), 32'(8'h00 & crc_ref(12'h3A5)));
        chk("crc.rx_tied", 32'(crc_rx), 32'd0);
        chk("crc.tx_first_tied", 32'(c1), 32'd0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
